// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: issue/writeback bundle between id_ex, ex_muldiv and regs.
// master drives the instruction side, slave is the execute unit.
interface ex_muldiv_if #(
  parameter int XLEN = 32
);
  logic [31:0]     inst_i;
  logic [XLEN-1:0] op1_i;
  logic [XLEN-1:0] op2_i;
  logic [4:0]      rd_addr_i;
  logic            flush_i;
  logic [4:0]      rd_addr_o;
  logic [XLEN-1:0] rd_data_o;
  logic            rd_wen_o;
  logic            hold_flag_o;
  logic            busy_o;

  modport master (
    output inst_i, op1_i, op2_i, rd_addr_i, flush_i,
    input  rd_addr_o, rd_data_o, rd_wen_o, hold_flag_o, busy_o
  );

  modport slave (
    input  inst_i, op1_i, op2_i, rd_addr_i, flush_i,
    output rd_addr_o, rd_data_o, rd_wen_o, hold_flag_o, busy_o
  );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle RV32M unit (shift-add mul, restoring div).
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier.
module ex_muldiv #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic        clk,
  input logic        rst,
  ex_muldiv_if.slave bus
);
  localparam int STEPS = XLEN / BITS_PER_CYCLE;
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
  state_t state_q, state_d;

  logic [2:0]      f3_q;
  logic [4:0]      rd_q;
  logic            neg_q;
  logic            spec_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] res_q;
  logic [2*XLEN:0] p_q;
  logic [2*XLEN:0] p_nx;
  logic [CW-1:0]   cnt_q;

  logic            is_md, start, is_div;
  logic            s1, s2, a_neg, b_neg;
  logic            special, fast_go, start_neg;
  logic [2:0]      f3;
  logic [XLEN-1:0] op1, op2, abs_a, abs_b;
  logic [XLEN-1:0] spec_val, start_res;
  logic [XLEN:0]   sum;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] dsel, result;
  logic            done_ok;
  logic            unused_bits;

  assign op1    = bus.op1_i;
  assign op2    = bus.op2_i;
  assign f3     = bus.inst_i[14:12];
  assign is_md  = (bus.inst_i[6:0] == 7'b0110011) &&
                  (bus.inst_i[31:25] == 7'b0000001);
  assign start  = (state_q == S_IDLE) && is_md &&
                  !bus.flush_i && !rst;
  assign is_div = f3[2];

  assign s1 = is_div ? !f3[0] : (f3 == 3'b001 || f3 == 3'b010);
  assign s2 = is_div ? !f3[0] : (f3 == 3'b001);
  assign a_neg = s1 && op1[XLEN-1];
  assign b_neg = s2 && op2[XLEN-1];
  assign abs_a = a_neg ? -op1 : op1;
  assign abs_b = b_neg ? -op2 : op2;

  // remainder follows the dividend, everything else the xor of signs
  assign start_neg = (is_div && f3[1]) ? a_neg : (a_neg ^ b_neg);

  assign special = is_div && ((op2 == '0) ||
                   (!f3[0] && op1 == MIN && op2 == '1));
  assign spec_val = (op2 == '0) ? (f3[1] ? op1 : '1)
                                : (f3[1] ? '0 : op1);

  assign unused_bits = ^{bus.inst_i[24:15], bus.inst_i[11:7]};

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN+1:0] fa, fb, fprod;
  logic unused_fast;
  assign fa = (2*XLEN+2)'($signed({s1 && op1[XLEN-1], op1}));
  assign fb = (2*XLEN+2)'($signed({s2 && op2[XLEN-1], op2}));
  assign fprod = fa * fb;
  assign unused_fast = ^fprod[2*XLEN+1:2*XLEN];
  assign fast_go = special || !is_div;
  assign start_res = special ? spec_val :
                     (f3 == 3'b000) ? fprod[XLEN-1:0]
                                    : fprod[2*XLEN-1:XLEN];
`else
  assign fast_go   = special;
  assign start_res = spec_val;
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next-state: flush aborts CALC/DONE, DONE lasts one cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = fast_go ? S_DONE : S_CALC;
      S_CALC: begin
        if (bus.flush_i)        state_d = S_IDLE;
        else if (cnt_q == LAST) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // one CALC step: BITS_PER_CYCLE shift-add or restoring sub-steps
  always_comb begin
    p_nx = p_q;
    sum  = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (f3_q[2]) begin
        p_nx = p_nx << 1;
        if (p_nx[2*XLEN:XLEN] >= {1'b0, b_q}) begin
          p_nx[2*XLEN:XLEN] = p_nx[2*XLEN:XLEN] - {1'b0, b_q};
          p_nx[0] = 1'b1;
        end
      end else begin
        sum  = p_nx[2*XLEN:XLEN] + (p_nx[0] ? {1'b0, b_q} : '0);
        p_nx = {sum, p_nx[XLEN-1:0]} >> 1;
      end
    end
  end

  // operand latch at start, iteration in CALC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f3_q   <= '0;
      rd_q   <= '0;
      neg_q  <= 1'b0;
      spec_q <= 1'b0;
      b_q    <= '0;
      res_q  <= '0;
      p_q    <= '0;
      cnt_q  <= '0;
    end else if (start) begin
      f3_q   <= f3;
      rd_q   <= bus.rd_addr_i;
      neg_q  <= start_neg;
      spec_q <= fast_go;
      b_q    <= is_div ? abs_b : abs_a;
      res_q  <= start_res;
      p_q    <= {{(XLEN+1){1'b0}}, is_div ? abs_a : abs_b};
      cnt_q  <= '0;
    end else if (state_q == S_CALC) begin
      p_q   <= p_nx;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // final sign fix-up and result selection
  always_comb begin
    prod = neg_q ? -p_q[2*XLEN-1:0] : p_q[2*XLEN-1:0];
    dsel = f3_q[1] ? p_q[2*XLEN-1:XLEN] : p_q[XLEN-1:0];
    if (neg_q) dsel = -dsel;
    if (spec_q)       result = res_q;
    else if (f3_q[2]) result = dsel;
    else if (f3_q == 3'b000) result = prod[XLEN-1:0];
    else              result = prod[2*XLEN-1:XLEN];
  end

  assign done_ok = (state_q == S_DONE) && !bus.flush_i;

  assign bus.rd_wen_o    = done_ok;
  assign bus.rd_addr_o   = done_ok ? rd_q : '0;
  assign bus.rd_data_o   = done_ok ? result : '0;
  assign bus.hold_flag_o = start || (state_q == S_CALC);
  assign bus.busy_o      = (state_q != S_IDLE);
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed vectors against an arithmetic model
// of ex_muldiv, checked every cycle at the falling edge.
module tb_ex_muldiv;
  localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ex_muldiv_if #(.XLEN(XLEN)) bus();

  ex_muldiv #(.XLEN(XLEN), .BITS_PER_CYCLE(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_inst(logic [2:0] f3, logic [4:0] rd);
    return {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] model_res(logic [2:0] f3,
                                            logic [31:0] a,
                                            logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    bit ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p = '0;
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(logic [2:0] f3,
                                   logic [31:0] a,
                                   logic [31:0] b);
    if (f3[2]) begin
      if (b == 0) return 1;
      if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
    end
    return MUL_LAT;
  endfunction

  // reference model state: one op in flight, cycles left to its write
  bit          m_act = 1'b0;
  int          m_left = 0;
  logic [31:0] m_res = '0;
  logic [4:0]  m_rd = '0;
  logic        c_md;
  logic        c_st;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_wen",  {31'b0, bus.rd_wen_o}, 32'd0);
      chk("rst_data", bus.rd_data_o, 32'd0);
      chk("rst_addr", {27'b0, bus.rd_addr_o}, 32'd0);
      chk("rst_hold", {31'b0, bus.hold_flag_o}, 32'd0);
      chk("rst_busy", {31'b0, bus.busy_o}, 32'd0);
      m_act = 1'b0;
    end else if (m_act) begin
      if (m_left == 0) begin
        if (bus.flush_i) begin
          chk("flush_wen", {31'b0, bus.rd_wen_o}, 32'd0);
        end else begin
          chk("wr_wen",  {31'b0, bus.rd_wen_o}, 32'd1);
          chk("wr_data", bus.rd_data_o, m_res);
          chk("wr_addr", {27'b0, bus.rd_addr_o}, {27'b0, m_rd});
        end
        chk("wr_hold", {31'b0, bus.hold_flag_o}, 32'd0);
        chk("wr_busy", {31'b0, bus.busy_o}, 32'd1);
        m_act = 1'b0;
      end else begin
        chk("run_wen",  {31'b0, bus.rd_wen_o}, 32'd0);
        chk("run_data", bus.rd_data_o, 32'd0);
        chk("run_hold", {31'b0, bus.hold_flag_o}, 32'd1);
        chk("run_busy", {31'b0, bus.busy_o}, 32'd1);
        if (bus.flush_i) m_act = 1'b0;
        else m_left--;
      end
    end else begin
      c_md = (bus.inst_i[6:0] == 7'b0110011) &&
             (bus.inst_i[31:25] == 7'b0000001);
      c_st = c_md && !bus.flush_i;
      chk("idle_wen",  {31'b0, bus.rd_wen_o}, 32'd0);
      chk("idle_data", bus.rd_data_o, 32'd0);
      chk("idle_addr", {27'b0, bus.rd_addr_o}, 32'd0);
      chk("idle_hold", {31'b0, bus.hold_flag_o}, {31'b0, c_st});
      chk("idle_busy", {31'b0, bus.busy_o}, 32'd0);
      if (c_st) begin
        m_act  = 1'b1;
        m_left = model_lat(bus.inst_i[14:12], bus.op1_i, bus.op2_i) - 1;
        m_res  = model_res(bus.inst_i[14:12], bus.op1_i, bus.op2_i);
        m_rd   = bus.rd_addr_i;
      end
    end
  end

  // act as id_ex: hold the instruction while hold_flag_o is high,
  // scramble operands after start, advance on the edge hold is low
  task automatic issue(string name, logic [2:0] f3,
                       logic [31:0] a, logic [31:0] b, logic [4:0] rd,
                       int flush_at, int rst_at,
                       logic [31:0] exp, int exp_lat);
    int  k;
    bit  h;
    bit  done;
    bus.inst_i    = mk_inst(f3, rd);
    bus.op1_i     = a;
    bus.op2_i     = b;
    bus.rd_addr_i = rd;
    bus.flush_i   = 1'b0;
    done = 1'b0;
    k = 0;
    while (!done && k < 200) begin
      bus.flush_i = (k == flush_at);
      @(negedge clk);
      h = bus.hold_flag_o;
      if (k > 0 && !h && !bus.flush_i && exp_lat > 0) begin
        chk({name, "_data"}, bus.rd_data_o, exp);
        chk({name, "_lat"}, k, exp_lat);
      end
      @(posedge clk);
      #1;
      if (bus.flush_i) begin
        bus.flush_i = 1'b0;
        bus.inst_i  = NOP;
        done = 1'b1;
      end else if (k > 0 && !h) begin
        bus.inst_i = NOP;
        done = 1'b1;
      end else if (k + 1 == rst_at) begin
        rst = 1'b1;
        bus.inst_i = NOP;
        #1;
        chk({name, "_arst_wen"},  {31'b0, bus.rd_wen_o}, 32'd0);
        chk({name, "_arst_data"}, bus.rd_data_o, 32'd0);
        chk({name, "_arst_hold"}, {31'b0, bus.hold_flag_o}, 32'd0);
        chk({name, "_arst_busy"}, {31'b0, bus.busy_o}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        done = 1'b1;
      end else begin
        bus.op1_i     = $urandom();
        bus.op2_i     = $urandom();
        bus.rd_addr_i = 5'($urandom());
      end
      k++;
    end
    chk({name, "_finished"}, {31'b0, done}, 32'd1);
  endtask

  task automatic idle(int n);
    bus.inst_i = NOP;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.inst_i    = NOP;
    bus.op1_i     = '0;
    bus.op2_i     = '0;
    bus.rd_addr_i = '0;
    bus.flush_i   = 1'b0;

    chk("pin_mul",    model_res(3'd0, 32'd7, 32'd6), 32'd42);
    chk("pin_mulhsu", model_res(3'd2, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFF);
    chk("pin_div",    model_res(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    chk("pin_rem",    model_res(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    issue("mul", 3'd0, 32'd7, 32'd6, 5'd7, -1, -1, 32'd42, MUL_LAT);
    idle(2);
    issue("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, -1, -1,
          32'h0, MUL_LAT);
    issue("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, -1, -1,
          32'hFFFF_FFFE, MUL_LAT);
    issue("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd5, -1, -1,
          32'hFFFF_FFFF, MUL_LAT);
    idle(1);
    issue("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd8, -1, -1,
          32'hFFFF_FFFD, 33);
    issue("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd9, -1, -1,
          32'hFFFF_FFFF, 33);
    issue("divu", 3'd5, 32'd100, 32'd7, 5'd10, -1, -1, 32'd14, 33);
    issue("remu", 3'd7, 32'd100, 32'd7, 5'd11, -1, -1, 32'd2, 33);
    idle(1);
    issue("div0", 3'd4, 32'd5, 32'd0, 5'd12, -1, -1, 32'hFFFF_FFFF, 1);
    issue("remu0", 3'd7, 32'd5, 32'd0, 5'd13, -1, -1, 32'd5, 1);
    issue("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, -1, -1,
          32'h8000_0000, 1);
    issue("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, -1, -1,
          32'h0, 1);
    idle(2);
    issue("mul_x0", 3'd0, 32'd3, 32'hFFFF_FFFE, 5'd0, -1, -1,
          32'hFFFF_FFFA, MUL_LAT);
    idle(1);
    issue("div_flush", 3'd5, 32'd123, 32'd10, 5'd16, 10, -1, 32'h0, 0);
    issue("mul_after", 3'd0, 32'd9, 32'd9, 5'd17, -1, -1, 32'd81, MUL_LAT);
    idle(1);
    issue("done_flush", 3'd4, 32'd5, 32'd0, 5'd18, 1, -1, 32'h0, 0);
    idle(2);
    issue("div_rst", 3'd4, 32'd1000, 32'd3, 5'd19, -1, 15, 32'h0, 0);
    idle(2);
    issue("b2b_div", 3'd4, 32'd1000, 32'd3, 5'd20, -1, -1, 32'd333, 33);
    issue("b2b_mul", 3'd0, 32'd12345, 32'd678, 5'd21, -1, -1,
          32'd8369910, MUL_LAT);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
